// File: rtl/cpu_pkg.sv
// Shared definitions for the load/store path: RV64 width codes, access-size
// codes and the memory controller FSM encoding.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  // funct3[1:0] is log2 of the access size in bytes
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    logic r;
    r = 1'b0;
    case (sz)
      SZ_B:    r = 1'b0;
      SZ_H:    r = off[0];
      SZ_W:    r = |off[1:0];
      default: r = |off;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering between the CPU's right-aligned data and the 64-bit RAM
// word: lane enables, store shift, and load extract with sign/zero extension.
module mem_lane
  import cpu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [2:0]  i_off,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rword,
  output logic [7:0]  o_be,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata
);

  logic [5:0]  w_shamt;
  logic [63:0] w_rsh;

  assign w_shamt = {i_off, 3'b000};
  assign o_wdata = i_wdata << w_shamt;
  assign w_rsh   = i_rword >> w_shamt;

  always_comb begin
    o_be = 8'h00;
    case (i_funct3[1:0])
      SZ_B:    o_be = 8'h01 << i_off;
      SZ_H:    o_be = 8'h03 << i_off;
      SZ_W:    o_be = 8'h0F << i_off;
      default: o_be = 8'hFF;
    endcase
  end

  always_comb begin
    o_rdata = 64'd0;
    case (i_funct3)
      F3_B:    o_rdata = {{56{w_rsh[7]}}, w_rsh[7:0]};
      F3_H:    o_rdata = {{48{w_rsh[15]}}, w_rsh[15:0]};
      F3_W:    o_rdata = {{32{w_rsh[31]}}, w_rsh[31:0]};
      F3_D:    o_rdata = w_rsh;
      F3_BU:   o_rdata = {56'd0, w_rsh[7:0]};
      F3_HU:   o_rdata = {48'd0, w_rsh[15:0]};
      F3_WU:   o_rdata = {32'd0, w_rsh[31:0]};
      default: o_rdata = 64'd0;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding CPU load/store controller in front of a fixed-latency
// 64-bit-wide synchronous RAM; faults are detected up front and never reach RAM.
module mem_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 13,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [63:0]       addr,
  input  logic [63:0]       wdata,
  input  logic [2:0]        funct3,
  output logic              ready,
  output logic [63:0]       rdata,
  output logic              err,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_be,
  output logic [63:0]       ram_wdata,
  input  logic [63:0]       ram_rdata,
  output state_t            o_dbg_state
);

  // Handshake: the CPU raises req with we/addr/wdata/funct3 stable and holds
  // them until ready; req is only looked at in IDLE. ready is a single-cycle
  // pulse carrying rdata/err, after which a new req is taken immediately.

  localparam logic [2:0] LAT_LAST = 3'(RAM_LAT - 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [ADDR_W+2:0]   r_addr;
  logic [63:0]         r_wdata;
  logic [2:0]          r_funct3;
  logic [2:0]          r_cnt;
  logic [63:0]         r_rdata;
  logic                r_err;

  logic                w_fault;
  logic                w_last;
  logic [7:0]          w_be;
  logic [63:0]         w_wdata_sh;
  logic [63:0]         w_rdata_ext;

  assign w_fault = (funct3 == F3_BAD) | (we & funct3[2]) |
                   misaligned(funct3[1:0], addr[2:0]) | (|addr[63:ADDR_W+3]);
  assign w_last  = (r_cnt == LAT_LAST);

  mem_lane u_lane (
    .i_funct3 (r_funct3),
    .i_off    (r_addr[2:0]),
    .i_wdata  (r_wdata),
    .i_rword  (ram_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata_sh),
    .o_rdata  (w_rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 64'd0;
      r_funct3 <= 3'd0;
      r_cnt    <= 3'd0;
      r_rdata  <= 64'd0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_we     <= we;
            r_addr   <= addr[ADDR_W+2:0];
            r_wdata  <= wdata;
            r_funct3 <= funct3;
            r_cnt    <= 3'd0;
            r_rdata  <= 64'd0;
            r_err    <= w_fault;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 3'd1;
          // RAM word is valid only in the final wait cycle
          if (w_last) r_rdata <= w_rdata_ext;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (req) w_next = w_fault ? ST_DONE : ST_ACCESS;
      ST_ACCESS: w_next = r_we ? ST_DONE : ST_WAIT;
      ST_WAIT:   if (w_last) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    rdata     = 64'd0;
    err       = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_be    = 8'h00;
    ram_wdata = 64'd0;
    case (r_state)
      ST_ACCESS: begin
        ram_cs    = 1'b1;
        ram_we    = r_we;
        ram_addr  = r_addr[ADDR_W+2:3];
        ram_be    = w_be;
        ram_wdata = w_wdata_sh;
      end
      ST_DONE: begin
        ready = 1'b1;
        rdata = r_rdata;
        err   = r_err;
      end
      default: ;
    endcase
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two instances (RAM_LAT 1 and 3) driven in lockstep, each
// with its own RAM model, checked against a byte-array reference memory.
module tb_mem_ctrl;
  import cpu_pkg::*;

  localparam int AW = 13;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic        we;
  logic [63:0] addr, wdata;
  logic [2:0]  funct3;

  logic          ready_a, err_a, ram_cs_a, ram_we_a;
  logic [63:0]   rdata_a, ram_wdata_a, ram_rdata_a;
  logic [AW-1:0] ram_addr_a;
  logic [7:0]    ram_be_a;
  state_t        dbg_a;

  logic          ready_b, err_b, ram_cs_b, ram_we_b;
  logic [63:0]   rdata_b, ram_wdata_b, ram_rdata_b;
  logic [AW-1:0] ram_addr_b;
  logic [7:0]    ram_be_b;
  state_t        dbg_b;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(AW), .RAM_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
    .funct3(funct3), .ready(ready_a), .rdata(rdata_a), .err(err_a),
    .ram_cs(ram_cs_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_be(ram_be_a),
    .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a), .o_dbg_state(dbg_a)
  );

  mem_ctrl #(.ADDR_W(AW), .RAM_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
    .funct3(funct3), .ready(ready_b), .rdata(rdata_b), .err(err_b),
    .ram_cs(ram_cs_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_be(ram_be_b),
    .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b), .o_dbg_state(dbg_b)
  );

  // ---------------- RAM models (garbage on the bus when not valid) ----------------
  logic [63:0] ram_a [0:(1<<AW)-1];
  logic [63:0] ram_b [0:(1<<AW)-1];
  logic [63:0] pipe_a;
  logic [63:0] pipe_b [0:2];

  assign ram_rdata_a = pipe_a;
  assign ram_rdata_b = pipe_b[2];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram_a[i] = 64'd0;
      ram_b[i] = 64'd0;
    end
  end

  always @(posedge clk) begin : ram_a_blk
    logic [63:0] m;
    m = ram_a[ram_addr_a];
    if (ram_cs_a && ram_we_a)
      for (int i = 0; i < 8; i++) if (ram_be_a[i]) m[8*i +: 8] = ram_wdata_a[8*i +: 8];
    if (ram_cs_a) ram_a[ram_addr_a] <= m;
    pipe_a <= ram_cs_a ? ram_a[ram_addr_a] : {$urandom, $urandom};
  end

  always @(posedge clk) begin : ram_b_blk
    logic [63:0] m;
    m = ram_b[ram_addr_b];
    if (ram_cs_b && ram_we_b)
      for (int i = 0; i < 8; i++) if (ram_be_b[i]) m[8*i +: 8] = ram_wdata_b[8*i +: 8];
    if (ram_cs_b) ram_b[ram_addr_b] <= m;
    pipe_b[0] <= ram_cs_b ? ram_b[ram_addr_b] : {$urandom, $urandom};
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  // ---------------- reference model: flat byte memory ----------------
  logic [7:0] ref_mem [0:65535];

  function automatic int size_of(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic logic model_fault(input logic w, input logic [63:0] a, input logic [2:0] f);
    return (f == 3'b111) || (w && f[2]) || ((int'(a[2:0]) % size_of(f)) != 0) || (a[63:16] != 48'd0);
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [2:0] f);
    int sz;
    logic [63:0] v;
    sz = size_of(f);
    v = 64'd0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[int'(a[15:0]) + i];
    if (!f[2] && sz < 8 && v[8*sz-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*sz));
    return v;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_a"}, {63'd0, |{ready_a, err_a, ram_cs_a, ram_we_a, ram_addr_a, ram_be_a, ram_wdata_a, rdata_a}}, 64'd0);
    check({name, "_b"}, {63'd0, |{ready_b, err_b, ram_cs_b, ram_we_b, ram_addr_b, ram_be_b, ram_wdata_b, rdata_b}}, 64'd0);
  endtask

  // One DUT's view of one cycle of an access.
  task automatic observe(input string tag, input int cyc, input int lat,
                         input logic cs, input logic rwe, input logic [AW-1:0] ra,
                         input logic [7:0] be, input logic [63:0] rwd,
                         input logic rdy, input logic [63:0] rd, input logic er,
                         input logic w, input logic [63:0] a, input logic [63:0] exp_wd,
                         input logic [7:0] exp_be, input logic exp_err, input logic [63:0] exp_rd,
                         inout bit got, inout int cs_n);
    if (cs) begin
      cs_n++;
      check({tag, "_cs_cycle"}, 64'(cyc), 64'd1);
      check({tag, "_ram_we"}, {63'd0, rwe}, {63'd0, w});
      check({tag, "_ram_addr"}, 64'(ra), 64'(a[AW+2:3]));
      check({tag, "_ram_be"}, 64'(be), 64'(exp_be));
      if (w) check({tag, "_ram_wdata"}, rwd, exp_wd);
    end else if (rwe) begin
      check({tag, "_we_without_cs"}, 64'd1, 64'd0);
    end
    if (rdy) begin
      got = 1'b1;
      check({tag, "_latency"}, 64'(cyc), 64'(lat));
      check({tag, "_err"}, {63'd0, er}, {63'd0, exp_err});
      check({tag, "_rdata"}, rd, exp_rd);
    end else if (rd != 64'd0 || er) begin
      check({tag, "_idle_rdata_err"}, {rd[62:0], er}, 64'd0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_access(input logic w, input logic [63:0] a, input logic [63:0] d,
                           input logic [2:0] f, input logic exp_err, input logic [63:0] exp_rd,
                           input string name);
    int sz, off, lat_a, lat_b, cs_na, cs_nb;
    bit got_a, got_b;
    logic [7:0]  exp_be;
    logic [63:0] exp_wd;
    sz     = size_of(f);
    off    = int'(a[2:0]);
    exp_be = 8'(((1 << sz) - 1) << off);
    exp_wd = d << (8 * off);
    lat_a  = exp_err ? 1 : (w ? 2 : 3);
    lat_b  = exp_err ? 1 : (w ? 2 : 5);
    @(negedge clk);
    we = w; addr = a; wdata = d; funct3 = f; req_a = 1'b1; req_b = 1'b1;
    got_a = 0; got_b = 0; cs_na = 0; cs_nb = 0;
    for (int cyc = 1; cyc <= 10 && !(got_a && got_b); cyc++) begin
      @(negedge clk);
      if (!got_a) begin
        observe({name, "_a"}, cyc, lat_a, ram_cs_a, ram_we_a, ram_addr_a, ram_be_a, ram_wdata_a,
                ready_a, rdata_a, err_a, w, a, exp_wd, exp_be, exp_err, exp_rd, got_a, cs_na);
        if (got_a) req_a = 1'b0;
      end
      if (!got_b) begin
        observe({name, "_b"}, cyc, lat_b, ram_cs_b, ram_we_b, ram_addr_b, ram_be_b, ram_wdata_b,
                ready_b, rdata_b, err_b, w, a, exp_wd, exp_be, exp_err, exp_rd, got_b, cs_nb);
        if (got_b) req_b = 1'b0;
      end
    end
    check({name, "_timeout_a"}, {63'd0, got_a}, 64'd1);
    check({name, "_timeout_b"}, {63'd0, got_b}, 64'd1);
    check({name, "_cs_count_a"}, 64'(cs_na), exp_err ? 64'd0 : 64'd1);
    check({name, "_cs_count_b"}, 64'(cs_nb), exp_err ? 64'd0 : 64'd1);
    req_a = 1'b0; req_b = 1'b0;
    if (!exp_err && w)
      for (int i = 0; i < sz; i++) ref_mem[int'(a[15:0]) + i] = d[8*i +: 8];
  endtask

  task automatic model_access(input logic w, input logic [63:0] a, input logic [63:0] d,
                              input logic [2:0] f, input string name);
    logic flt;
    flt = model_fault(w, a, f);
    do_access(w, a, d, f, flt, (flt || w) ? 64'd0 : model_load(a, f), name);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic [2:0]  f;
    logic        exp_err;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic        w;
    logic [63:0] a, d;
    logic [2:0]  f;
    int          bitpos;

    vecs[0]  = '{1'b1, 64'h10,    64'h1122334455667788, 3'b011, 1'b0, 64'h0};
    vecs[1]  = '{1'b1, 64'h13,    64'hAB,               3'b000, 1'b0, 64'h0};
    vecs[2]  = '{1'b0, 64'h13,    64'h0,                3'b100, 1'b0, 64'hAB};
    vecs[3]  = '{1'b1, 64'h0,     64'h80000000_0000FF80, 3'b011, 1'b0, 64'h0};
    vecs[4]  = '{1'b0, 64'h0,     64'h0,                3'b000, 1'b0, 64'hFFFFFFFF_FFFFFF80};
    vecs[5]  = '{1'b0, 64'h0,     64'h0,                3'b101, 1'b0, 64'hFF80};
    vecs[6]  = '{1'b0, 64'h4,     64'h0,                3'b010, 1'b0, 64'hFFFFFFFF_80000000};
    vecs[7]  = '{1'b0, 64'h6,     64'h0,                3'b010, 1'b1, 64'h0};
    vecs[8]  = '{1'b0, 64'h0,     64'h0,                3'b111, 1'b1, 64'h0};
    vecs[9]  = '{1'b0, 64'h10000, 64'h0,                3'b011, 1'b1, 64'h0};
    vecs[10] = '{1'b1, 64'h0,     64'h55,               3'b100, 1'b1, 64'h0};
    vecs[11] = '{1'b0, 64'h10,    64'h0,                3'b011, 1'b0, 64'h11223344_AB667788};

    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;

    reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
    we = 1'b0; addr = 64'd0; wdata = 64'd0; funct3 = 3'd0;
    repeat (3) @(negedge clk);
    check_quiet("reset_outputs");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("post_reset_outputs");

    for (int i = 0; i < 12; i++)
      do_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].f, vecs[i].exp_err, vecs[i].exp_rd,
                $sformatf("vec%0d", i));

    // Reset while both instances are in WAIT of a load
    @(negedge clk);
    we = 1'b0; addr = 64'h10; funct3 = 3'b011; req_a = 1'b1; req_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_wait_b", 64'(dbg_b), 64'(ST_WAIT));
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    check_quiet("abort_during_reset");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_quiet($sformatf("abort_after_%0d", i));
    end
    model_access(1'b0, 64'h10, 64'd0, 3'b011, "after_abort_load");

    // Randomized traffic against the byte-array model
    for (int n = 0; n < 150; n++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      d = {$urandom, $urandom};
      a = {48'd0, 16'($urandom_range(0, 511))};
      if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & 3'(~(size_of(f) - 1));
      if ($urandom_range(0, 15) == 0) begin
        bitpos = 16 + $urandom_range(0, 47);
        a[bitpos] = 1'b1;
      end
      model_access(w, a, d, f, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 13, sets the RAM word-index width (RAM holds 2^ADDR_W 64-bit words, 64 KiB at default).
REQ-002 Parameter RAM_LAT, default 1, legal 1..4, sets the RAM read latency in cycles from ram_cs to ram_rdata valid.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  CPU access request; sampled only in IDLE.
REQ-006 we  input  1  1 = store, 0 = load.
REQ-007 addr  input  64  byte address.
REQ-008 wdata  input  64  store data, right-aligned (bits [size-1:0] used).
REQ-009 funct3  input  3  RV64 width code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; 111 illegal.
REQ-010 ready  output  1  one-cycle completion pulse.
REQ-011 rdata  output  64  load result, extended per funct3, valid while ready=1.
REQ-012 err  output  1  fault flag, valid while ready=1.
REQ-013 ram_cs  output  1  RAM select, one-cycle pulse per access.
REQ-014 ram_we  output  1  RAM write enable, asserted only with ram_cs.
REQ-015 ram_addr  output  ADDR_W  RAM word index = addr[ADDR_W+2:3].
REQ-016 ram_be  output  8  byte-lane enables, bit i = byte i (little-endian).
REQ-017 ram_wdata  output  64  lane-shifted store data.
REQ-018 ram_rdata  input  64  RAM read data.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, WAIT, DONE.
REQ-020 IDLE: on req=1, latch we/addr/wdata/funct3; go to DONE with err=1 if fault, else ACCESS; req=0 stays IDLE.
REQ-021 Fault SHALL be: funct3=111, store with funct3[2]=1, addr not aligned to access size, or addr[63:ADDR_W+3] nonzero.
REQ-022 A faulting access SHALL issue no RAM cycle (ram_cs stays 0).
REQ-023 ACCESS: ram_cs=1 for exactly one cycle; stores assert ram_we=1 and go to DONE; loads go to WAIT.
REQ-024 ram_be SHALL be B: 1<<off, H: 3<<off, W: 0x0F<<off, D: 0xFF, with off=addr[2:0]; ram_wdata = wdata<<(8*off).
REQ-025 WAIT SHALL count RAM_LAT cycles, capture ram_rdata in the last, and go to DONE.
REQ-026 Load extraction: shift captured word right by 8*off, keep size bytes; B/H/W sign-extend, BU/HU/WU/D zero-extend.
REQ-027 DONE: ready=1 for one cycle, rdata/err driven from registers, then return to IDLE.
REQ-028 Latency from req cycle T: fault ready at T+1; store ready at T+2; load ready at T+2+RAM_LAT.
REQ-029 req while not in IDLE SHALL be ignored; the CPU holds req until ready.
REQ-030 rdata SHALL be 0 and err 0 whenever ready=0; rdata=0 for stores.
REQ-031 Back-to-back: req high in the cycle after DONE SHALL start a new access.

Reset
REQ-032 reset=1 SHALL force IDLE and clear latched fields and the wait counter on the next edge, aborting any access in flight.
REQ-033 All outputs SHALL be 0 during and after reset until a new req.
REQ-034 Reset mid-access SHALL produce no ready pulse for the aborted access; an already-issued RAM write is not undone.

Structure
REQ-035 funct3 width codes and FSM state encodings SHALL live in the shared package cpu_pkg.
REQ-036 Lane logic (be/shift/extend) SHALL be one combinational sub-module, mem_lane.

Verification
REQ-037 Store D addr 0x10 wdata 0x1122334455667788 -> ram_cs, ram_we at T+1, ram_addr 2, be 0xFF; ready at T+2, err 0.
REQ-038 Store B addr 0x13 wdata 0xAB -> be 0x08, ram_wdata 0xAB000000; load BU addr 0x13 -> rdata 0xAB.
REQ-039 RAM word 0x80000000_0000FF80 at addr 0: load B addr 0 -> 0xFFFFFFFFFFFFFF80; LHU addr 0 -> 0xFF80; LW addr 4 -> 0xFFFFFFFF80000000; ready at T+3 (RAM_LAT=1).
REQ-040 Load W addr 0x6 -> ready at T+1, err=1, no ram_cs; funct3=111 -> same.
REQ-041 Load at addr 0x10000 (ADDR_W=13) -> err=1; store with funct3=100 -> err=1.
REQ-042 Reset asserted in WAIT of a load (RAM_LAT=3) -> no ready; outputs 0; next load completes normally.
